// File: rtl/ddr_scrub_pkg.sv
// Shared types and AXI constants for the DDR scrub writer.
package ddr_scrub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scrb_state_t;

  localparam int unsigned AXI_BEAT_BYTES = 64;
  localparam logic [2:0]  AXI_SIZE_64B   = 3'b110;

endpackage

// File: rtl/ddr_scrub_wbeat.sv
// W-channel beat generator: emits one burst per issued AW, never ahead of it.
module ddr_scrub_wbeat #(
  parameter int unsigned BURST_LEN_MINUS1 = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic [31:0] aw_issued_d_i,
  input  logic        wready_i,
  output logic        wvalid_o,
  output logic        wlast_o,
  output logic [31:0] w_bursts_o
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN_MINUS1);

  logic [7:0]  beat_q, beat_d;
  logic [31:0] bursts_q, bursts_d;
  logic        wvalid_q, wvalid_d;
  logic        wlast_q, wlast_d;

  always_comb begin
    beat_d   = beat_q;
    bursts_d = bursts_q;
    if (clr_i) begin
      beat_d   = '0;
      bursts_d = '0;
    end else if (wvalid_q && wready_i) begin
      if (wlast_q) begin
        beat_d   = '0;
        bursts_d = bursts_q + 32'd1;
      end else begin
        beat_d = beat_q + 8'd1;
      end
    end
  end

  // Looking at the next-cycle AW count lets W start the cycle after its AW handshake.
  always_comb begin
    wvalid_d = (bursts_d < aw_issued_d_i);
    wlast_d  = wvalid_d && (beat_d == LAST_BEAT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q   <= '0;
      bursts_q <= '0;
      wvalid_q <= 1'b0;
      wlast_q  <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      bursts_q <= bursts_d;
      wvalid_q <= wvalid_d;
      wlast_q  <= wlast_d;
    end
  end

  assign wvalid_o   = wvalid_q;
  assign wlast_o    = wlast_q;
  assign w_bursts_o = bursts_q;

endmodule

// File: rtl/ddr_scrub_wr.sv
// AXI4 write-only master that fills [0, MAX_ADDR] with a repeated 32-bit pattern.
// IDLE: waiting for start | RUN: issuing AW/W | DRAIN: all W sent, collecting B
module ddr_scrub_wr
  import ddr_scrub_pkg::*;
#(
  parameter logic [63:0] MAX_ADDR         = 64'h3_FFFF_FFFF,
  parameter int unsigned BURST_LEN_MINUS1 = 15,
  parameter int unsigned MAX_OUTSTANDING  = 8
) (
  input  logic         clk_main_a0,
  input  logic         rst_main_sync,
  input  logic         start,
  input  logic [31:0]  pattern,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [63:0]  cur_addr,
  output logic [15:0]  awid,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [15:0]  bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam logic [63:0] BURST_BYTES = 64'((BURST_LEN_MINUS1 + 1) * AXI_BEAT_BYTES);
  localparam logic [31:0] TOTAL       = 32'((MAX_ADDR + 64'd1) / BURST_BYTES);
  localparam logic [31:0] MAX_OUT     = 32'(MAX_OUTSTANDING);

  scrb_state_t state_q, state_d;
  logic [31:0] aw_q, aw_d;
  logic [31:0] b_q, b_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [31:0] pattern_q, pattern_d;
  logic [63:0] wstrb_q, wstrb_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        awvalid_q, awvalid_d;
  logic        start_acc, aw_hs, b_hs;
  logic [31:0] w_bursts;
  logic        bid_unused;

  assign bid_unused = ^bid;

  // A start landing on the done cycle is dropped so each accepted start yields one done.
  always_comb begin
    start_acc  = (state_q == IDLE) && start && !done_q;
    aw_hs      = awvalid_q && awready;
    b_hs       = bvalid && busy_q;
    state_d    = state_q;
    aw_d       = aw_q;
    b_d        = b_q;
    cur_addr_d = cur_addr_q;
    pattern_d  = pattern_q;
    wstrb_d    = wstrb_q;
    err_d      = err_q;
    done_d     = 1'b0;

    if (start_acc) begin
      state_d    = RUN;
      aw_d       = '0;
      b_d        = '0;
      cur_addr_d = '0;
      err_d      = 1'b0;
      pattern_d  = pattern;
      wstrb_d    = '1;
    end else begin
      if (aw_hs) begin
        aw_d       = aw_q + 32'd1;
        cur_addr_d = cur_addr_q + BURST_BYTES;
      end
      if (b_hs) begin
        b_d = b_q + 32'd1;
        if (bresp != 2'b00) err_d = 1'b1;
      end
      case (state_q)
        RUN: begin
          if (b_d == TOTAL) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if ((aw_q == TOTAL) && (w_bursts == TOTAL)) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (b_d == TOTAL) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    busy_d    = (state_d != IDLE);
    awvalid_d = (state_d == RUN) && (aw_d < TOTAL) && ((aw_d - b_d) < MAX_OUT);
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      state_q    <= IDLE;
      aw_q       <= '0;
      b_q        <= '0;
      cur_addr_q <= '0;
      pattern_q  <= '0;
      wstrb_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      awvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_q       <= aw_d;
      b_q        <= b_d;
      cur_addr_q <= cur_addr_d;
      pattern_q  <= pattern_d;
      wstrb_q    <= wstrb_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      awvalid_q  <= awvalid_d;
    end
  end

  ddr_scrub_wbeat #(
    .BURST_LEN_MINUS1 (BURST_LEN_MINUS1)
  ) u_wbeat (
    .clk_i         (clk_main_a0),
    .rst_i         (rst_main_sync),
    .clr_i         (start_acc),
    .aw_issued_d_i (aw_d),
    .wready_i      (wready),
    .wvalid_o      (wvalid),
    .wlast_o       (wlast),
    .w_bursts_o    (w_bursts)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cur_addr = cur_addr_q;
  assign awid     = '0;
  assign awaddr   = cur_addr_q;
  assign awlen    = 8'(BURST_LEN_MINUS1);
  assign awsize   = AXI_SIZE_64B;
  assign awvalid  = awvalid_q;
  assign wdata    = {(AXI_BEAT_BYTES / 4){pattern_q}};
  assign wstrb    = wstrb_q;
  assign bready   = busy_q;

endmodule

// File: doc/ddr_scrub_wr.md
# ddr_scrub_wr

AXI4 write-only master that scrubs the CL DDR by writing a fixed 32-bit pattern over a configured address range on command. It sits directly upstream of the shell DDR port (cl_sh_ddr_aw*/w*/b* channels) and is muxed with user traffic ahead of it. The SIM/HW ranges are set by parameter (8 KB in SIM, 16 GB in hardware).

## Interface
- MAX_ADDR, 64'h3FFFFFFFF: last byte address scrubbed, inclusive. MAX_ADDR+1 must be a multiple of the burst byte count.
- BURST_LEN_MINUS1, 15: AXI awlen; 512-bit beats, so burst bytes = (BURST_LEN_MINUS1+1)*64.
- MAX_OUTSTANDING, 8: maximum issued AW bursts still awaiting B (range 1–255).
- clk_main_a0  in  1  sole clock.
- rst_main_sync  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; ignored while busy.
- pattern  in  32  data word, sampled on an accepted start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the final B is received.
- err  out  1  sticky flag for any bresp != OKAY; cleared on an accepted start.
- cur_addr  out  64  address of the next AW to issue.
- awid 16 / awaddr 64 / awlen 8 / awsize 3 / awvalid 1  out; awready in.
- wdata 512 / wstrb 64 / wlast 1 / wvalid 1  out; wready in.
- bid 16 / bresp 2 / bvalid 1  in; bready out.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start. Actions on transition:
  - latch pattern;
  - clear counters and err;
  - cur_addr = 0.
- AW issue, in RUN:
  - awvalid is high while aw_issued < TOTAL and (aw_issued - b_recv) < MAX_OUTSTANDING.
  - On each AW handshake: awaddr += burst bytes, aw_issued += 1.
  - Fixed fields: awid = 0, awsize = 3'b110, awlen = BURST_LEN_MINUS1.
  - TOTAL = (MAX_ADDR+1)/burst bytes.
- W issue:
  - The W burst for index k starts only after AW k has handshaken. W never leads AW.
  - wvalid is high while w_bursts < aw_issued.
  - Beat counter runs 0..BURST_LEN_MINUS1. wlast is high on the final beat.
  - wdata = pattern replicated 16×; wstrb = all ones.
- B handling:
  - bready is held high in RUN/DRAIN. Each bvalid increments b_recv.
  - bresp != 0 sets err. bid is not checked.
- RUN -> DRAIN when aw_issued == TOTAL and w_bursts == TOTAL.
- DRAIN -> IDLE when b_recv == TOTAL. done pulses in that cycle.
- Counters are 32 bits wide. aw_issued - b_recv never underflows, because a B cannot precede its AW.
- awvalid and wvalid, once asserted, stay high with stable payload until the handshake (AXI rule).
- Reset mid-operation:
  - all valids, busy and done drop in the next cycle;
  - state -> IDLE and err -> 0;
  - outstanding B responses are abandoned, with bready = 0 after reset.

## Timing
- Values in reset: awvalid, wvalid, wlast, bready, busy, done and err are 0; cur_addr and awaddr are 0; wdata and wstrb are 0.
- Start accepted at cycle N: busy = 1 and awvalid = 1 at N+1.
- The earliest wvalid is the cycle after the first AW handshake.
- Throughput with awready, wready and bvalid always high: one beat per cycle, with no bubble between consecutive bursts.
- done is asserted one cycle after the last B handshake is registered. busy falls in the same cycle done rises.
- A start arriving in the same cycle as done is ignored. A start one cycle later is accepted.
- Outputs are registered. There is no combinational path from ready/valid inputs to valid outputs.

## Structure
- Package ddr_scrub_pkg:
  - state enum scrb_state_t {IDLE, RUN, DRAIN};
  - constants AXI_BEAT_BYTES = 64 and AXI_SIZE_64B = 3'b110.
- A sub-module is optional: ddr_scrub_wbeat, the W beat generator (burst/beat counters, wlast). The AW/B control stays in the top.

## Test plan
- MAX_ADDR = 'h1FFF, LEN_M1 = 15, with always-ready slave and pattern 'hA5A5_5A5A:
  - 8 AWs at addresses 0x0, 0x400 … 0x1C00;
  - 128 beats, with wlast on every 16th;
  - done 1 cycle after the 8th B;
  - err = 0.
- MAX_OUTSTANDING = 2 and bvalid withheld: awvalid drops after 2 AWs. Releasing one B re-raises awvalid next cycle.
- Slave holds awready = 0 for 5 cycles and randomises wready: payload stays stable while valid is high, wvalid never precedes the first AW, and the beat count is exact.
- Slave returns bresp = 2'b10 on burst 3: err = 1 at completion. A new start clears err.
- Reset asserted for 1 cycle after 3 beats of burst 0: all outputs are 0 next cycle. A fresh start re-scrubs from address 0.
- Start pulses while busy, including the done cycle: ignored, so there is exactly one done per accepted start.
